// File: rtl/irq_source_conditioner.sv
// Purpose : synchronize raw interrupt lines, capture edges or pass levels, hold pending, mask, claim-encode.
// Latency : irqIn rising before edge k -> pending at edge k+SYNC_STAGES; outputs combinational from pending.
// Backpressure: none; pending bits hold until acked (edge lines) or the source drops the line (level lines).
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset; clears synchronizers, prev sample and pending
//   irqIn       raw asynchronous interrupt lines, active-high
//   irqMask     1 = line enabled towards the core (gates outputs only)
//   ackValid    one-cycle acknowledge strobe from the core
//   ackId       index of the line being acknowledged
//   irqBus      pending & irqMask, feeds the interrupt controller
//   claimValid  |irqBus
//   claimId     lowest set index of irqBus, 0 when nothing is claimable
module irq_source_conditioner #(
    parameter int                         EXT_IRQ_COUNT  = 4,
    parameter int                         SYNC_STAGES    = 2,
    parameter logic [EXT_IRQ_COUNT-1:0]   EDGE_SENSITIVE = {EXT_IRQ_COUNT{1'b1}},
    parameter int                         ID_W           = (EXT_IRQ_COUNT > 1) ? $clog2(EXT_IRQ_COUNT) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [EXT_IRQ_COUNT-1:0]  irqIn,
    input  logic [EXT_IRQ_COUNT-1:0]  irqMask,
    input  logic                      ackValid,
    input  logic [ID_W-1:0]           ackId,
    output logic [EXT_IRQ_COUNT-1:0]  irqBus,
    output logic                      claimValid,
    output logic [ID_W-1:0]           claimId
);

    // Synchronizer chain: stage 0 samples the raw pins, the last stage is the
    // first value safe to use in logic.
    logic [EXT_IRQ_COUNT-1:0] sync_q [SYNC_STAGES];
    logic [EXT_IRQ_COUNT-1:0] sync;
    logic [EXT_IRQ_COUNT-1:0] prev;
    logic [EXT_IRQ_COUNT-1:0] pending;
    logic [EXT_IRQ_COUNT-1:0] pending_d;
    logic [EXT_IRQ_COUNT-1:0] set_edge;
    logic [EXT_IRQ_COUNT-1:0] clr_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= irqIn;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // prev resets to 0, so a line held high across reset release is seen as
    // one fresh edge once it emerges from the synchronizer.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= '0;
        end else begin
            prev <= sync;
        end
    end

    // Acks only match indices that exist, so out-of-range ackId values fall
    // through without touching any pending bit.
    always_comb begin
        set_edge  = sync & ~prev;
        clr_ack   = '0;
        pending_d = '0;
        for (int i = 0; i < EXT_IRQ_COUNT; i++) begin
            clr_ack[i] = ackValid && (ackId == ID_W'(i));
            if (EDGE_SENSITIVE[i]) begin
                // A new edge coinciding with an ack wins, so it is not lost.
                pending_d[i] = set_edge[i] | (pending[i] & ~clr_ack[i]);
            end else begin
                // Level lines simply mirror the synchronized input.
                pending_d[i] = sync[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_d;
        end
    end

    // Mask gates only the outputs; masked edge lines keep latching so that
    // unmasking presents them immediately.
    assign irqBus     = pending & irqMask;
    assign claimValid = |irqBus;

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        claimId = '0;
        for (int i = EXT_IRQ_COUNT - 1; i >= 0; i--) begin
            if (irqBus[i]) begin
                claimId = ID_W'(i);
            end
        end
    end

endmodule
